sc_phase_gen: RTL and testbench

- Generates the non-overlapping two-phase switch clocks phi1/phi2 that drive the switched_capacitor_filter sampling switches.
- Phase width and dead time are programmable. A one-cycle sample strobe marks the end of each phi2 (integrate) phase, and a period counter tracks completed periods.
- Sits in the digital control domain. Its phi1/phi2 go directly to the analog switch gates, so the block must be glitch-free and must never overlap the two phases.

---
 rtl/sc_phase_gen.sv | 135 +++++++++++++
 tb/tb_sc_phase_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_phase_gen.sv
// Non-overlapping two-phase switch-clock generator for the switched-capacitor filter.
// One-hot FSM whose PHI1/PHI2 flops drive the switch gates directly.
module sc_phase_gen #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned PCNT_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [CNT_W-1:0]  ph_width,
  input  logic [CNT_W-1:0]  dead_width,
  output logic              phi1,
  output logic              phi2,
  output logic              busy,
  output logic              sample_strb,
  output logic [PCNT_W-1:0] period_cnt
);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_PHI1  = 5'b00010,
    S_DEAD1 = 5'b00100,
    S_PHI2  = 5'b01000,
    S_DEAD2 = 5'b10000
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    w_q, w_d;
  logic [CNT_W-1:0]    d_q, d_d;
  logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
  logic                strb_q, strb_d;
  logic                busy_q, busy_d;
  logic                en_q;
  logic [CNT_W-1:0]    ph_cl, dd_cl;
  logic                last;

  function automatic logic [CNT_W-1:0] clamp1(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  // Next-state, counter reload and config latch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    d_d     = d_q;
    pcnt_d  = pcnt_q;
    strb_d  = 1'b0;
    ph_cl   = clamp1(ph_width);
    dd_cl   = clamp1(dead_width);
    last    = (cnt_q == '0);
    if (!last) cnt_d = cnt_q - CNT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (en_q) begin
          state_d = S_PHI1;
          w_d     = ph_cl;
          d_d     = dd_cl;
          cnt_d   = ph_cl - CNT_W'(1);
        end
      end
      S_PHI1: begin
        if (last) begin
          state_d = S_DEAD1;
          cnt_d   = d_q - CNT_W'(1);
        end
      end
      S_DEAD1: begin
        if (last) begin
          state_d = S_PHI2;
          cnt_d   = w_q - CNT_W'(1);
        end
      end
      S_PHI2: begin
        if (last) begin
          state_d = S_DEAD2;
          cnt_d   = d_q - CNT_W'(1);
          strb_d  = 1'b1;
        end
      end
      S_DEAD2: begin
        // en only matters here; the running period always completes
        if (last) begin
          pcnt_d = pcnt_q + PCNT_W'(1);
          if (en) begin
            state_d = S_PHI1;
            w_d     = ph_cl;
            d_d     = dd_cl;
            cnt_d   = ph_cl - CNT_W'(1);
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      w_q     <= CNT_W'(1);
      d_q     <= CNT_W'(1);
      pcnt_q  <= '0;
      strb_q  <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      d_q     <= d_d;
      pcnt_q  <= pcnt_d;
      strb_q  <= strb_d;
      busy_q  <= busy_d;
      en_q    <= en;
    end
  end

  assign phi1        = state_q[1];
  assign phi2        = state_q[3];
  assign busy        = busy_q;
  assign sample_strb = strb_q;
  assign period_cnt  = pcnt_q;

endmodule

// File: tb/tb_sc_phase_gen.sv
// Directed bench for sc_phase_gen: a position-in-period reference model plus
// hand-derived spot checks, a 4-bit period counter wrap and a random-width soak.
module tb_sc_phase_gen;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [7:0]  ph_width;
  logic [7:0]  dead_width;

  logic        phi1, phi2, busy, strb;
  logic [3:0]  pcnt4;
  logic        phi1_b, phi2_b, busy_b, strb_b;
  logic [15:0] pcnt16;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_busy, m_pend;
  int m_pos, m_w, m_d, m_pcnt;
  logic prev_phi1, prev_phi2;

  always #5 clk = ~clk;

  sc_phase_gen #(.CNT_W(8), .PCNT_W(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .en(en), .ph_width(ph_width), .dead_width(dead_width),
    .phi1(phi1), .phi2(phi2), .busy(busy), .sample_strb(strb), .period_cnt(pcnt4)
  );

  sc_phase_gen u_dut16 (
    .clk(clk), .rstn(rstn), .en(en), .ph_width(ph_width), .dead_width(dead_width),
    .phi1(phi1_b), .phi2(phi2_b), .busy(busy_b), .sample_strb(strb_b), .period_cnt(pcnt16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp1(input logic [7:0] v);
    return (v == 8'd0) ? 1 : int'(v);
  endfunction

  function automatic bit e_phi1();
    return m_busy && (m_pos < m_w);
  endfunction
  function automatic bit e_phi2();
    return m_busy && (m_pos >= m_w + m_d) && (m_pos < 2*m_w + m_d);
  endfunction
  function automatic bit e_strb();
    return m_busy && (m_pos == 2*m_w + m_d);
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_pend = 1'b0; m_pos = 0; m_w = 1; m_d = 1; m_pcnt = 0;
  endtask

  task automatic model_adv(input bit en_s, input logic [7:0] ph_s, input logic [7:0] dd_s);
    if (!m_busy) begin
      if (m_pend) begin
        m_busy = 1'b1; m_pos = 0; m_w = clamp1(ph_s); m_d = clamp1(dd_s);
      end
    end else if (m_pos == 2*m_w + 2*m_d - 1) begin
      m_pcnt++;
      if (en_s) begin
        m_pos = 0; m_w = clamp1(ph_s); m_d = clamp1(dd_s);
      end else begin
        m_busy = 1'b0;
      end
    end else begin
      m_pos++;
    end
    m_pend = en_s;
  endtask

  // One clock: capture inputs at the edge, advance model, compare 1ns later
  task automatic step();
    bit en_s, rst_s;
    logic [7:0] ph_s, dd_s;
    @(posedge clk);
    en_s = en; rst_s = rstn; ph_s = ph_width; dd_s = dead_width;
    #1;
    if (!rst_s) model_reset();
    else model_adv(en_s, ph_s, dd_s);
    chk("phi1", 32'(phi1), 32'(e_phi1()));
    chk("phi2", 32'(phi2), 32'(e_phi2()));
    chk("strb", 32'(strb), 32'(e_strb()));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("pcnt4", 32'(pcnt4), 32'(m_pcnt % 16));
    chk("pcnt16", 32'(pcnt16), 32'(m_pcnt % 65536));
    chk("overlap", 32'(phi1 & phi2), 32'd0);
    chk("gap", 32'((phi2 & prev_phi1) | (phi1 & prev_phi2)), 32'd0);
    prev_phi1 = phi1;
    prev_phi2 = phi2;
  endtask

  initial begin
    bit found;
    bit seen16;
    prev_phi1 = 1'b0;
    prev_phi2 = 1'b0;
    model_reset();
    rstn = 1'b0; en = 1'b0; ph_width = 8'd3; dead_width = 8'd2;

    #3;
    chk("rst_phi1", 32'(phi1), 32'd0);
    chk("rst_phi2", 32'(phi2), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strb", 32'(strb), 32'd0);
    chk("rst_pcnt", 32'(pcnt16), 32'd0);

    @(negedge clk);
    rstn = 1'b1; en = 1'b1;

    // 3/2 start, mid-period width change, stop during PHI1 of the fourth period
    for (int c = 0; c <= 55; c++) begin
      step();
      if (c == 0)  chk("start_c0_phi1", 32'(phi1), 32'd0);
      if (c == 1)  chk("start_c1_phi1", 32'(phi1), 32'd1);
      if (c == 4)  chk("dead1_c4_phi1", 32'(phi1), 32'd0);
      if (c == 6)  chk("phi2_c6", 32'(phi2), 32'd1);
      if (c == 9)  chk("strb_c9", 32'(strb), 32'd1);
      if (c == 11) chk("phi1_c11", 32'(phi1), 32'd1);
      if (c == 11) chk("pcnt_c11", 32'(pcnt16), 32'd1);
      if (c == 16) ph_width = 8'd5;
      if (c == 18) chk("old_w_phi2_c18", 32'(phi2), 32'd1);
      if (c == 19) chk("old_w_phi2_c19", 32'(phi2), 32'd0);
      if (c == 25) chk("new_w_phi1_c25", 32'(phi1), 32'd1);
      if (c == 26) chk("new_w_phi1_c26", 32'(phi1), 32'd0);
      if (c == 36) en = 1'b0;
      if (c == 44) chk("stop_phi2_c44", 32'(phi2), 32'd1);
      if (c == 47) chk("stop_strb_c47", 32'(strb), 32'd1);
      if (c == 48) chk("stop_busy_c48", 32'(busy), 32'd1);
      if (c == 49) chk("stop_busy_c49", 32'(busy), 32'd0);
      if (c == 49) chk("stop_pcnt_c49", 32'(pcnt16), 32'd4);
      if (c == 55) chk("idle_c55", 32'(busy), 32'd0);
    end

    // zero widths clamp to 1/1
    ph_width = 8'd0; dead_width = 8'd0; en = 1'b1;
    for (int c = 56; c <= 76; c++) begin
      step();
      if (c == 57) chk("clamp_phi1_c57", 32'(phi1), 32'd1);
      if (c == 58) chk("clamp_gap_c58", 32'(phi1 | phi2), 32'd0);
      if (c == 59) chk("clamp_phi2_c59", 32'(phi2), 32'd1);
      if (c == 60) chk("clamp_strb_c60", 32'(strb), 32'd1);
      if (c == 61) chk("clamp_phi1_c61", 32'(phi1), 32'd1);
      if (c == 61) chk("clamp_pcnt_c61", 32'(pcnt16), 32'd5);
    end

    // asynchronous reset while phi2 is high
    ph_width = 8'd3; dead_width = 8'd2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (e_phi2()) found = 1'b1;
    end
    chk("wait_phi2_timeout", 32'(found), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_phi2", 32'(phi2), 32'd0);
    chk("arst_phi1", 32'(phi1), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_strb", 32'(strb), 32'd0);
    chk("arst_pcnt", 32'(pcnt16), 32'd0);
    model_reset();
    prev_phi1 = 1'b0;
    prev_phi2 = 1'b0;
    step();
    rstn = 1'b1;
    step();
    chk("restart_phi1_lat0", 32'(phi1), 32'd0);
    step();
    chk("restart_phi1_lat1", 32'(phi1), 32'd1);

    // 4-bit period counter wrap
    found = 1'b0;
    seen16 = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (m_pcnt == 16 && !seen16) begin
        seen16 = 1'b1;
        chk("wrap_to_zero", 32'(pcnt4), 32'd0);
      end
      if (m_pcnt == 17) found = 1'b1;
    end
    chk("wrap_timeout", 32'(found), 32'd1);
    chk("wrap4_one", 32'(pcnt4), 32'd1);
    chk("wrap16_17", 32'(pcnt16), 32'd17);

    // random-width soak, widths change every cycle
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      ph_width   = 8'($urandom_range(0, 4));
      dead_width = 8'($urandom_range(0, 3));
      step();
      if (m_pcnt >= 517) found = 1'b1;
    end
    chk("soak_timeout", 32'(found), 32'd1);

    en = 1'b0;
    for (int i = 0; i < 40; i++) step();
    chk("final_busy", 32'(busy), 32'd0);
    chk("final_phi", 32'(phi1 | phi2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
